serial_logic_unit: RTL and testbench

Bit-serial logic/arithmetic unit that consumes one bit pair per clock and produces a WIDTH-bit result using AND/OR/XOR gate functions plus a 1-bit full adder. It is the sequential stage built directly on top of the 2-input gate primitives, and it drives the word-level result into the datapath. It is used for gate-level datapath exercises where area matters more than latency.

---
 rtl/serial_logic_unit_if.sv | 24 ++
 rtl/serial_logic_unit.sv | 103 ++++++++++
 tb/tb_serial_logic_unit.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_logic_unit_if.sv
// Request/result bundle for the bit-serial logic unit: operands and op in,
// busy/done handshake and word-level result out.
interface serial_logic_unit_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;

  modport master (
    output start, op, a, b,
    input  busy, done, result, carry_out
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, carry_out
  );
endinterface

// File: rtl/serial_logic_unit.sv
// Bit-serial AND/OR/XOR/ADD unit: one operand bit pair per clock, LSB first,
// result assembled in a right-shifting accumulator and published on completion.
module serial_logic_unit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_logic_unit_if.slave   bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {OP_AND = 2'b00, OP_OR = 2'b01, OP_XOR = 2'b10, OP_ADD = 2'b11} op_t;

  state_t           state, state_nxt;
  op_t              opr;
  logic [WIDTH-1:0] sa, sb, acc, acc_nxt, res_q;
  logic [CNT_W-1:0] cnt;
  logic             carry, carry_nxt, cout_q;
  logic             load, last, bit_val;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    last      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == CNT_W'(WIDTH - 1)) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        // Back-to-back start skips IDLE entirely
        load      = bus.start;
        state_nxt = bus.start ? SHIFT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bit_val   = 1'b0;
    carry_nxt = 1'b0;
    unique case (opr)
      OP_AND: bit_val = sa[0] & sb[0];
      OP_OR:  bit_val = sa[0] | sb[0];
      OP_XOR: bit_val = sa[0] ^ sb[0];
      OP_ADD: begin
        bit_val   = sa[0] ^ sb[0] ^ carry;
        carry_nxt = (sa[0] & sb[0]) | (sa[0] & carry) | (sb[0] & carry);
      end
      default: bit_val = 1'b0;
    endcase
    acc_nxt = {bit_val, acc[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa     <= '0;
      sb     <= '0;
      acc    <= '0;
      opr    <= OP_AND;
      cnt    <= '0;
      carry  <= 1'b0;
      res_q  <= '0;
      cout_q <= 1'b0;
    end else if (load) begin
      sa    <= bus.a;
      sb    <= bus.b;
      opr   <= op_t'(bus.op);
      cnt   <= '0;
      carry <= 1'b0;
    end else if (state == SHIFT) begin
      sa    <= sa >> 1;
      sb    <= sb >> 1;
      acc   <= acc_nxt;
      carry <= carry_nxt;
      if (last) begin
        res_q  <= acc_nxt;
        cout_q <= (opr == OP_ADD) & carry_nxt;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign bus.busy      = (state == SHIFT);
  assign bus.done      = (state == DONE);
  assign bus.result    = res_q;
  assign bus.carry_out = cout_q;
endmodule

// File: tb/tb_serial_logic_unit.sv
// Randomized and directed checks of serial_logic_unit at WIDTH=8 and WIDTH=5
// against a word-level arithmetic reference.
module tb_serial_logic_unit;
  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  serial_logic_unit_if #(.WIDTH(8)) bus8 ();
  serial_logic_unit_if #(.WIDTH(5)) bus5 ();

  serial_logic_unit #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_logic_unit #(.WIDTH(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Word-level reference: plain bitwise ops and integer addition
  function automatic void ref_op(input int unsigned w, input logic [1:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic co);
    logic [32:0] s;
    logic [31:0] m;
    m  = (32'h1 << w) - 32'h1;
    co = 1'b0;
    case (op)
      2'b00: r = a & b & m;
      2'b01: r = (a | b) & m;
      2'b10: r = (a ^ b) & m;
      default: begin
        s  = {1'b0, a & m} + {1'b0, b & m};
        r  = s[31:0] & m;
        co = s[w];
      end
    endcase
  endfunction

  // Called at a negedge; returns after the start edge has passed
  task automatic start8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    bus8.start = 1'b1; bus8.op = op; bus8.a = a; bus8.b = b;
    @(negedge clk);
    bus8.start = 1'b0;
  endtask

  task automatic start5(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b);
    bus5.start = 1'b1; bus5.op = op; bus5.a = a; bus5.b = b;
    @(negedge clk);
    bus5.start = 1'b0;
  endtask

  // lat counts clock edges after the start edge until done is seen
  task automatic wait_done8(input bit toggle, output int lat, output int busyc, output int holdbad);
    logic [7:0] prev_r;
    logic       prev_c;
    prev_r = bus8.result; prev_c = bus8.carry_out;
    lat = 0; busyc = 0; holdbad = 0;
    while (!bus8.done && lat < 40) begin
      if (bus8.busy) busyc++;
      if (bus8.result !== prev_r || bus8.carry_out !== prev_c) holdbad++;
      if (toggle) begin
        bus8.start = $urandom_range(0, 1) != 0;
        bus8.op    = 2'($urandom);
        bus8.a     = 8'($urandom);
        bus8.b     = 8'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    bus8.start = 1'b0;
  endtask

  task automatic wait_done5(output int lat, output int busyc);
    lat = 0; busyc = 0;
    while (!bus5.done && lat < 40) begin
      if (bus5.busy) busyc++;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, busyc, holdbad, dones, busys;
    logic [31:0] er;
    logic        ec;
    logic [1:0]  op;
    logic [7:0]  ra, rb;
    logic [4:0]  qa, qb;

    rst_n = 1'b0;
    bus8.start = 1'b0; bus8.op = '0; bus8.a = '0; bus8.b = '0;
    bus5.start = 1'b0; bus5.op = '0; bus5.a = '0; bus5.b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus8.busy), 0);
    check("rst_done", 32'(bus8.done), 0);
    check("rst_result", 32'(bus8.result), 0);
    check("rst_carry", 32'(bus8.carry_out), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Test 1: AND
    start8(2'b00, 8'hF0, 8'h3C);
    wait_done8(1'b0, lat, busyc, holdbad);
    check("t1_latency", 32'(lat), 8);
    check("t1_busy_cycles", 32'(busyc), 8);
    check("t1_done_not_busy", 32'(bus8.busy), 0);
    check("t1_result", 32'(bus8.result), 32'h30);
    check("t1_carry", 32'(bus8.carry_out), 0);
    @(negedge clk);
    check("t1_done_pulse", 32'(bus8.done), 0);

    // Test 2: OR then XOR back-to-back
    start8(2'b01, 8'hF0, 8'h3C);
    wait_done8(1'b0, lat, busyc, holdbad);
    check("t2_or_result", 32'(bus8.result), 32'hFC);
    bus8.start = 1'b1; bus8.op = 2'b10;
    @(negedge clk);
    bus8.start = 1'b0;
    check("t2_no_bubble", 32'(bus8.busy), 1);
    check("t2_no_extra_done", 32'(bus8.done), 0);
    wait_done8(1'b0, lat, busyc, holdbad);
    check("t2_xor_latency", 32'(lat), 8);
    check("t2_xor_result", 32'(bus8.result), 32'hCC);
    @(negedge clk);
    check("t2_idle_after", 32'(bus8.busy | bus8.done), 0);

    // Test 3: ADD corner cases
    start8(2'b11, 8'hFF, 8'h01);
    wait_done8(1'b0, lat, busyc, holdbad);
    check("t3a_result", 32'(bus8.result), 32'h00);
    check("t3a_carry", 32'(bus8.carry_out), 1);
    start8(2'b11, 8'h7F, 8'h01);
    wait_done8(1'b0, lat, busyc, holdbad);
    check("t3b_hold", 32'(holdbad), 0);
    check("t3b_result", 32'(bus8.result), 32'h80);
    check("t3b_carry", 32'(bus8.carry_out), 0);
    start8(2'b11, 8'hA5, 8'h5A);
    wait_done8(1'b0, lat, busyc, holdbad);
    check("t3c_result", 32'(bus8.result), 32'hFF);
    check("t3c_carry", 32'(bus8.carry_out), 0);

    // Test 4: inputs toggling during SHIFT
    start8(2'b11, 8'h10, 8'h20);
    wait_done8(1'b1, lat, busyc, holdbad);
    check("t4_latency", 32'(lat), 8);
    check("t4_hold", 32'(holdbad), 0);
    check("t4_result", 32'(bus8.result), 32'h30);
    check("t4_carry", 32'(bus8.carry_out), 0);
    @(negedge clk);
    check("t4_single_done", 32'(bus8.done | bus8.busy), 0);

    // Test 5: async reset mid-ADD
    start8(2'b11, 8'h33, 8'h44);
    repeat (4) @(negedge clk);
    check("t5_busy_before", 32'(bus8.busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_busy", 32'(bus8.busy), 0);
    check("t5_done", 32'(bus8.done), 0);
    check("t5_result", 32'(bus8.result), 0);
    check("t5_carry", 32'(bus8.carry_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0; busys = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus8.done) dones++;
      if (bus8.busy) busys++;
    end
    check("t5_no_done", 32'(dones), 0);
    check("t5_stay_idle", 32'(busys), 0);

    // Test 6: random regression, WIDTH=8
    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom); ra = 8'($urandom); rb = 8'($urandom);
      ref_op(8, op, 32'(ra), 32'(rb), er, ec);
      start8(op, ra, rb);
      wait_done8(1'b0, lat, busyc, holdbad);
      check("r8_latency", 32'(lat), 8);
      check("r8_busy_cycles", 32'(busyc), 8);
      check("r8_result", 32'(bus8.result), er);
      check("r8_carry", 32'(bus8.carry_out), 32'(ec));
      if ($urandom_range(0, 1) != 0) @(negedge clk);
    end

    // Test 6: random regression, WIDTH=5
    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom); qa = 5'($urandom); qb = 5'($urandom);
      ref_op(5, op, 32'(qa), 32'(qb), er, ec);
      start5(op, qa, qb);
      wait_done5(lat, busyc);
      check("r5_latency", 32'(lat), 5);
      check("r5_busy_cycles", 32'(busyc), 5);
      check("r5_done_not_busy", 32'(bus5.busy), 0);
      check("r5_result", 32'(bus5.result), er);
      check("r5_carry", 32'(bus5.carry_out), 32'(ec));
      if ($urandom_range(0, 1) != 0) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
